// File: rtl/fmap_pingpong_buf_if.sv
// rtl/fmap_pingpong_buf_if.sv - producer/consumer bus of the feature-map ping-pong buffer
interface fmap_pingpong_buf_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 15
);
    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_done;
    logic                  wr_ready;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_avail;
    logic                  rd_release;
    logic                  wr_bank;
    logic                  rd_bank;
    logic [2:0]            err_flags;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_done, rd_req, rd_addr, rd_release,
        input  wr_ready, rd_data, rd_valid, rd_avail, wr_bank, rd_bank, err_flags
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_done, rd_req, rd_addr, rd_release,
        output wr_ready, rd_data, rd_valid, rd_avail, wr_bank, rd_bank, err_flags
    );
endinterface

// File: rtl/fmap_pingpong_buf.sv
// rtl/fmap_pingpong_buf.sv - double-banked feature-map buffer between CNN layers
// Optional FMAP_BUF_CLEAR_EN: released banks are zero-filled before reuse.
module fmap_pingpong_buf #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 28830,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input logic                clk,
    input logic                reset,
    fmap_pingpong_buf_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_EMPTY    = 3'd0,
        S_FILLING  = 3'd1,
        S_FULL     = 3'd2,
        S_DRAINING = 3'd3
`ifdef FMAP_BUF_CLEAR_EN
        , S_CLEARING = 3'd4
`endif
    } bank_state_t;

    bank_state_t           state     [2];
    bank_state_t           state_nxt [2];
    logic                  wr_bank_q, wr_bank_nxt;
    logic                  rd_bank_q, rd_bank_nxt;
    logic [2:0]            err_q, err_nxt;
    logic                  wr_done_q, rd_release_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] mem [2][DEPTH];

    logic wr_ready, rd_avail, wr_in_range, rd_in_range;
    logic wr_fire, rd_fire, done_edge, rel_edge, done_ok, rel_ok;
    logic [IDX_W-1:0] wr_idx, rd_idx;

    assign wr_ready    = (state[wr_bank_q] == S_EMPTY) || (state[wr_bank_q] == S_FILLING);
    assign rd_avail    = (state[rd_bank_q] == S_FULL)  || (state[rd_bank_q] == S_DRAINING);
    assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH_W;
    assign rd_in_range = {1'b0, bus.rd_addr} < DEPTH_W;
    assign wr_fire     = bus.wr_valid && wr_ready && wr_in_range;
    assign rd_fire     = bus.rd_req && rd_avail && rd_in_range;
    assign done_edge   = bus.wr_done && !wr_done_q;
    assign rel_edge    = bus.rd_release && !rd_release_q;
    assign done_ok     = done_edge && wr_ready;
    assign rel_ok      = rel_edge && rd_avail;
    assign wr_idx      = bus.wr_addr[IDX_W-1:0];
    assign rd_idx      = bus.rd_addr[IDX_W-1:0];

`ifdef FMAP_BUF_CLEAR_EN
    logic [IDX_W-1:0] clr_cnt [2];
    logic [1:0]       clr_last;

    always_comb begin
        clr_last = '0;
        for (int b = 0; b < 2; b++)
            clr_last[b] = (state[b] == S_CLEARING) && (clr_cnt[b] == IDX_W'(DEPTH - 1));
    end
`endif

    // done_ok and rel_ok can never target the same bank: they need disjoint states
    always_comb begin
        state_nxt[0] = state[0];
        state_nxt[1] = state[1];
        wr_bank_nxt  = wr_bank_q;
        rd_bank_nxt  = rd_bank_q;
        err_nxt      = err_q;
        if (wr_fire && state[wr_bank_q] == S_EMPTY)
            state_nxt[wr_bank_q] = S_FILLING;
        if (rd_fire && state[rd_bank_q] == S_FULL)
            state_nxt[rd_bank_q] = S_DRAINING;
        if (done_ok) begin
            state_nxt[wr_bank_q] = S_FULL;
            wr_bank_nxt          = !wr_bank_q;
        end
        if (rel_ok) begin
`ifdef FMAP_BUF_CLEAR_EN
            state_nxt[rd_bank_q] = S_CLEARING;
`else
            state_nxt[rd_bank_q] = S_EMPTY;
`endif
            rd_bank_nxt = !rd_bank_q;
        end
`ifdef FMAP_BUF_CLEAR_EN
        for (int b = 0; b < 2; b++)
            if (clr_last[b]) state_nxt[b] = S_EMPTY;
`endif
        if ((bus.wr_valid && !wr_ready) || (done_edge && !wr_ready)) err_nxt[0] = 1'b1;
        if (bus.rd_req && !rd_avail)                                 err_nxt[1] = 1'b1;
        if ((bus.wr_valid && !wr_in_range) || (bus.rd_req && !rd_in_range))
            err_nxt[2] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state[0]     <= S_EMPTY;
            state[1]     <= S_EMPTY;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            err_q        <= '0;
            wr_done_q    <= 1'b0;
            rd_release_q <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
`ifdef FMAP_BUF_CLEAR_EN
            clr_cnt[0]   <= '0;
            clr_cnt[1]   <= '0;
`endif
        end else begin
            state[0]     <= state_nxt[0];
            state[1]     <= state_nxt[1];
            wr_bank_q    <= wr_bank_nxt;
            rd_bank_q    <= rd_bank_nxt;
            err_q        <= err_nxt;
            wr_done_q    <= bus.wr_done;
            rd_release_q <= bus.rd_release;
            rd_valid_q   <= rd_fire;
            if (rd_fire) rd_data_q <= mem[rd_bank_q][rd_idx];
`ifdef FMAP_BUF_CLEAR_EN
            for (int b = 0; b < 2; b++)
                if (state[b] == S_CLEARING)
                    clr_cnt[b] <= clr_last[b] ? '0 : clr_cnt[b] + 1'b1;
`endif
        end
    end

    // Ownership is exclusive, so each bank sees at most one writer per cycle
    always_ff @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (wr_fire && wr_bank_q == b[0])
                mem[b][wr_idx] <= bus.wr_data;
`ifdef FMAP_BUF_CLEAR_EN
            else if (state[b] == S_CLEARING)
                mem[b][clr_cnt[b]] <= '0;
`endif
        end
    end

    assign bus.wr_ready  = wr_ready;
    assign bus.rd_avail  = rd_avail;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.wr_bank   = wr_bank_q;
    assign bus.rd_bank   = rd_bank_q;
    assign bus.err_flags = err_q;
endmodule

// File: tb/tb_fmap_pingpong_buf.sv
// tb/tb_fmap_pingpong_buf.sv - directed self-checking bench for fmap_pingpong_buf
module tb_fmap_pingpong_buf;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

`ifdef FMAP_BUF_CLEAR_EN
    localparam logic        EXP_RDY_AFTER_REL = 1'b0;
    localparam logic [15:0] EXP_BANK0_WORD0   = 16'd0;
`else
    localparam logic        EXP_RDY_AFTER_REL = 1'b1;
    localparam logic [15:0] EXP_BANK0_WORD0   = 16'd100;
`endif

    fmap_pingpong_buf_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fmap_pingpong_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.wr_valid   = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.wr_done    = 1'b0;
        bus.rd_req     = 1'b0;
        bus.rd_addr    = '0;
        bus.rd_release = 1'b0;
    endtask

    task automatic wait_wr_ready;
        for (int n = 0; n < 40 && !bus.wr_ready; n++) step();
        checks++;
        if (bus.wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL wait_wr_ready got=%0b exp=1", bus.wr_ready);
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({bus.wr_ready, bus.rd_avail, bus.rd_valid, bus.wr_bank, bus.rd_bank, bus.err_flags} !== 8'b1000_0000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=10000000",
                     {bus.wr_ready, bus.rd_avail, bus.rd_valid, bus.wr_bank, bus.rd_bank, bus.err_flags});
        end
        checks++;
        if (bus.rd_data !== 16'd0) begin
            failures++;
            $display("FAIL reset_rd_data got=%0d exp=0", bus.rd_data);
        end
        step(); step();
        reset = 1'b1;
        step();
        // write accepted into old bank on the same cycle as the done edge
        bus.wr_valid = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 16'd7; bus.wr_done = 1'b1;
        step();
        bus.wr_done = 1'b0; bus.wr_addr = 5'd16;
        bus.rd_req = 1'b1; bus.rd_addr = 5'd0;
        step();
        checks++;
        if ({bus.wr_bank, bus.rd_valid, bus.err_flags, bus.rd_data} !== {1'b1, 1'b1, 3'b100, 16'd7}) begin
            failures++;
            $display("FAIL pre_reset_state got=%b/%b/%b/%0d exp=1/1/100/7",
                     bus.wr_bank, bus.rd_valid, bus.err_flags, bus.rd_data);
        end
        idle_inputs();
        bus.wr_valid = 1'b1; bus.wr_addr = 5'd1; bus.wr_data = 16'd9;
        step();
        reset = 1'b0;
        #2;
        checks++;
        if ({bus.wr_ready, bus.rd_avail, bus.rd_valid, bus.wr_bank, bus.rd_bank, bus.err_flags, bus.rd_data}
            !== {8'b1000_0000, 16'd0}) begin
            failures++;
            $display("FAIL reset_mid_fill got=%b rd_data=%0d exp=10000000 rd_data=0",
                     {bus.wr_ready, bus.rd_avail, bus.rd_valid, bus.wr_bank, bus.rd_bank, bus.err_flags}, bus.rd_data);
        end
        idle_inputs();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_frame;
        for (int i = 0; i < 16; i++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = AW'(i); bus.wr_data = DW'(100 + i);
            step();
        end
        bus.wr_valid = 1'b0;
        checks++;
        if ({bus.wr_bank, bus.rd_avail, bus.wr_ready} !== 3'b001) begin
            failures++;
            $display("FAIL sf_before_done got=%b exp=001", {bus.wr_bank, bus.rd_avail, bus.wr_ready});
        end
        bus.wr_done = 1'b1;
        step();
        bus.wr_done = 1'b0;
        checks++;
        if ({bus.wr_bank, bus.rd_bank, bus.rd_avail} !== 3'b101) begin
            failures++;
            $display("FAIL sf_after_done got=%b exp=101", {bus.wr_bank, bus.rd_bank, bus.rd_avail});
        end
        for (int i = 0; i < 16; i++) begin
            bus.rd_req = 1'b1; bus.rd_addr = AW'(i);
            step();
            checks++;
            if ({bus.rd_valid, bus.rd_data} !== {1'b1, DW'(100 + i)}) begin
                failures++;
                $display("FAIL sf_read[%0d] got=%b/%0d exp=1/%0d", i, bus.rd_valid, bus.rd_data, 100 + i);
            end
        end
        bus.rd_req = 1'b0;
        step();
        checks++;
        if ({bus.rd_valid, bus.rd_data} !== {1'b0, 16'd115}) begin
            failures++;
            $display("FAIL sf_idle_hold got=%b/%0d exp=0/115", bus.rd_valid, bus.rd_data);
        end
    endtask

    task automatic test_ping_pong;
        for (int i = 0; i < 16; i++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = AW'(i); bus.wr_data = DW'(200 + i);
            bus.wr_done = (i == 15);
            bus.rd_req = 1'b1; bus.rd_addr = AW'(15 - i);
            step();
            checks++;
            if ({bus.rd_valid, bus.rd_data} !== {1'b1, DW'(115 - i)}) begin
                failures++;
                $display("FAIL pp_overlap_read[%0d] got=%b/%0d exp=1/%0d", i, bus.rd_valid, bus.rd_data, 115 - i);
            end
        end
        idle_inputs();
        checks++;
        if ({bus.wr_bank, bus.rd_bank, bus.wr_ready, bus.rd_avail} !== 4'b0001) begin
            failures++;
            $display("FAIL pp_both_full got=%b exp=0001", {bus.wr_bank, bus.rd_bank, bus.wr_ready, bus.rd_avail});
        end
        bus.wr_valid = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 16'd999;
        step();
        bus.wr_valid = 1'b0;
        bus.wr_done  = 1'b1;
        step();
        bus.wr_done = 1'b0;
        checks++;
        if ({bus.err_flags, bus.wr_ready, bus.wr_bank} !== 5'b001_0_0) begin
            failures++;
            $display("FAIL pp_overflow got=%b exp=00100", {bus.err_flags, bus.wr_ready, bus.wr_bank});
        end
        bus.rd_release = 1'b1;
        step();
        bus.rd_release = 1'b0;
        checks++;
        if ({bus.rd_bank, bus.rd_avail, bus.wr_ready} !== {2'b11, EXP_RDY_AFTER_REL}) begin
            failures++;
            $display("FAIL pp_release got=%b exp=11%b", {bus.rd_bank, bus.rd_avail, bus.wr_ready}, EXP_RDY_AFTER_REL);
        end
        for (int i = 0; i < 16; i++) begin
            bus.rd_req = 1'b1; bus.rd_addr = AW'(i);
            step();
            checks++;
            if ({bus.rd_valid, bus.rd_data} !== {1'b1, DW'(200 + i)}) begin
                failures++;
                $display("FAIL pp_bank1_read[%0d] got=%b/%0d exp=1/%0d", i, bus.rd_valid, bus.rd_data, 200 + i);
            end
        end
        bus.rd_req = 1'b0;
    endtask

    task automatic test_underflow_range;
        bus.rd_release = 1'b1;
        step();
        bus.rd_release = 1'b0;
        checks++;
        if ({bus.rd_bank, bus.rd_avail} !== 2'b00) begin
            failures++;
            $display("FAIL ur_release got=%b exp=00", {bus.rd_bank, bus.rd_avail});
        end
        bus.rd_req = 1'b1; bus.rd_addr = 5'd3;
        step();
        bus.rd_req = 1'b0;
        checks++;
        if ({bus.rd_valid, bus.rd_data, bus.err_flags} !== {1'b0, 16'd215, 3'b011}) begin
            failures++;
            $display("FAIL ur_underflow got=%b/%0d/%b exp=0/215/011", bus.rd_valid, bus.rd_data, bus.err_flags);
        end
        bus.wr_valid = 1'b1; bus.wr_addr = 5'd16; bus.wr_data = 16'h5555;
        step();
        bus.wr_valid = 1'b0;
        checks++;
        if ({bus.err_flags, bus.wr_ready, bus.wr_bank} !== 5'b111_1_0) begin
            failures++;
            $display("FAIL ur_range got=%b exp=11110", {bus.err_flags, bus.wr_ready, bus.wr_bank});
        end
        bus.wr_done = 1'b1;
        step();
        bus.wr_done = 1'b0;
        checks++;
        if ({bus.wr_bank, bus.rd_avail} !== 2'b11) begin
            failures++;
            $display("FAIL ur_empty_frame got=%b exp=11", {bus.wr_bank, bus.rd_avail});
        end
        bus.rd_req = 1'b1; bus.rd_addr = 5'd0;
        step();
        checks++;
        if ({bus.rd_valid, bus.rd_data} !== {1'b1, EXP_BANK0_WORD0}) begin
            failures++;
            $display("FAIL ur_dropped_writes got=%b/%0d exp=1/%0d", bus.rd_valid, bus.rd_data, EXP_BANK0_WORD0);
        end
        bus.rd_addr = 5'd16;
        step();
        bus.rd_req = 1'b0;
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL ur_read_range got=%b exp=0", bus.rd_valid);
        end
    endtask

    task automatic test_simultaneous;
        wait_wr_ready();
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = AW'(i); bus.wr_data = DW'(300 + i);
            step();
        end
        bus.wr_valid   = 1'b0;
        bus.wr_done    = 1'b1;
        bus.rd_release = 1'b1;
        step();
        bus.rd_release = 1'b0;
        checks++;
        if ({bus.wr_bank, bus.rd_bank, bus.rd_avail} !== 3'b011) begin
            failures++;
            $display("FAIL sim_edges got=%b exp=011", {bus.wr_bank, bus.rd_bank, bus.rd_avail});
        end
        for (int n = 0; n < 4; n++) step();
        bus.wr_done = 1'b0;
        checks++;
        if ({bus.wr_bank, bus.rd_bank} !== 2'b01) begin
            failures++;
            $display("FAIL sim_level_once got=%b exp=01", {bus.wr_bank, bus.rd_bank});
        end
        bus.rd_req = 1'b1; bus.rd_addr = 5'd2;
        step();
        bus.rd_req = 1'b0;
        checks++;
        if ({bus.rd_valid, bus.rd_data} !== {1'b1, 16'd302}) begin
            failures++;
            $display("FAIL sim_read got=%b/%0d exp=1/302", bus.rd_valid, bus.rd_data);
        end
        wait_wr_ready();
        bus.wr_done = 1'b1;
        step();
        bus.wr_done = 1'b0;
        checks++;
        if (bus.wr_bank !== 1'b1) begin
            failures++;
            $display("FAIL sim_new_edge got=%b exp=1", bus.wr_bank);
        end
    endtask

`ifdef FMAP_BUF_CLEAR_EN
    task automatic test_clear;
        int cnt;
        cnt = 0;
        bus.rd_release = 1'b1;
        step();
        bus.rd_release = 1'b0;
        for (int n = 0; n < 40 && !bus.wr_ready; n++) begin
            cnt++;
            step();
        end
        checks++;
        if (cnt !== 16) begin
            failures++;
            $display("FAIL clr_busy_cycles got=%0d exp=16", cnt);
        end
        bus.wr_done = 1'b1;
        step();
        bus.wr_done = 1'b0;
        bus.rd_release = 1'b1;
        step();
        bus.rd_release = 1'b0;
        bus.rd_req = 1'b1; bus.rd_addr = 5'd2;
        step();
        bus.rd_req = 1'b0;
        checks++;
        if ({bus.rd_bank, bus.rd_valid, bus.rd_data} !== {2'b11, 16'd0}) begin
            failures++;
            $display("FAIL clr_zero_read got=%b/%b/%0d exp=1/1/0", bus.rd_bank, bus.rd_valid, bus.rd_data);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_ping_pong();
        test_underflow_range();
        test_simultaneous();
`ifdef FMAP_BUF_CLEAR_EN
        test_clear();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fmap_pingpong_buf.md
Name: fmap_pingpong_buf

Overview:
- Double-banked feature-map memory that sits between two CNN layers, e.g. conv2d to max_pool, or max_pool to fully_connected.
- The producer side accepts a layer's output stream (output_valid, output_addr, data, done).
- The consumer side serves the next layer's address-driven reads with a registered 1-cycle response.
- Bank swapping lets layer N write frame k+1 while layer N+1 reads frame k.

Parameters:
- DATA_WIDTH, 16, word width (signed fixed-point, not interpreted).
- DEPTH, 28830, words per bank (31x31x30 pooled map).
- ADDR_WIDTH, $clog2(DEPTH), address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_valid  in  1  producer write strobe.
- wr_addr  in  ADDR_WIDTH  producer write address.
- wr_data  in  DATA_WIDTH  producer write data.
- wr_done  in  1  producer layer done (level or pulse; rising edge used).
- wr_ready  out  1  current write bank is writable.
- rd_req  in  1  consumer read request.
- rd_addr  in  ADDR_WIDTH  consumer read address.
- rd_data  out  DATA_WIDTH  read data, registered.
- rd_valid  out  1  rd_data valid; drives the consumer's input_valid.
- rd_avail  out  1  a complete frame is readable.
- rd_release  in  1  consumer layer done (rising edge used).
- wr_bank  out  1  bank currently targeted by writes.
- rd_bank  out  1  bank currently targeted by reads.
- err_flags  out  3  sticky errors: [0] write overflow, [1] read underflow, [2] address out of range.

Behaviour:
- Reset (reset=0, async):
  - Both banks EMPTY; wr_bank=0, rd_bank=0.
  - wr_ready=1, rd_avail=0, rd_valid=0, rd_data=0, err_flags=0.
  - Edge-detect registers cleared. Memory contents are undefined.
  - Reset mid-frame discards both banks' state immediately.
- Per-bank state: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Write side:
  - wr_ready=1 iff state[wr_bank] is EMPTY or FILLING.
  - wr_valid && wr_ready && wr_addr<DEPTH: the word is written to wr_bank; EMPTY moves to FILLING.
  - wr_valid && !wr_ready: write dropped, err_flags[0] set.
  - wr_valid && wr_addr>=DEPTH: write dropped, err_flags[2] set.
- wr_done rising edge (previous sample 0, current 1) while wr_ready:
  - state[wr_bank] -> FULL and wr_bank toggles, next cycle.
  - A write in the same cycle as the edge is accepted into the old bank first.
  - An edge with zero writes still marks the bank FULL (empty frame).
  - An edge while !wr_ready sets err_flags[0] and nothing else changes.
- rd_avail=1 iff state[rd_bank] is FULL or DRAINING.
- Read side:
  - rd_req && rd_avail && rd_addr<DEPTH: the next cycle gives rd_data=mem[rd_bank][rd_addr] and rd_valid=1. The first such request moves FULL to DRAINING.
  - rd_req && !rd_avail: rd_valid=0 next cycle, rd_data holds, err_flags[1] set.
  - rd_req && rd_addr>=DEPTH: rd_valid=0, err_flags[2] set.
  - No rd_req: rd_valid=0 next cycle, rd_data holds its last value.
- Read latency is 1 cycle, fully pipelined: one request per cycle and back-to-back addresses are allowed.
- rd_release rising edge while rd_avail: state[rd_bank] -> EMPTY and rd_bank toggles. A read in the same cycle is served from the old bank. An edge while !rd_avail is ignored.
- Simultaneous events:
  - wr_done and rd_release in the same cycle act on their respective banks independently.
  - If wr_bank==rd_bank in that cycle, the wr_done transition to FULL and the rd_release transition are both evaluated on the pre-edge state. Legally this only happens for a bank that is EMPTY/FILLING for the writer, so rd_release is ignored.
- Write and read never address the same bank in the same cycle, because ownership is exclusive. Each bank is an independent 1W1R array.
- err_flags clear only on reset.

Optional Feature:
- Macro: FMAP_BUF_CLEAR_EN.
- Defined: rd_release moves the bank to an extra state CLEARING.
  - An internal counter writes 0 to addresses 0..DEPTH-1, one per cycle, then the bank goes EMPTY (DEPTH cycles).
  - wr_ready=0 while the targeted bank is CLEARING.
  - A wr_done edge during CLEARING sets err_flags[0].
- Not defined: rd_release makes the bank EMPTY immediately; the CLEARING state and its counter are absent.

Test Plan:
- Reset defaults: DEPTH=16; assert reset=0 mid-fill -> all outputs at reset values immediately, wr_bank=0, rd_avail=0.
- Single frame: write addr i with data 100+i for i=0..15, pulse wr_done -> wr_bank=1 and rd_avail=1 next cycle. Reads of addr 0..15 back-to-back return 100..115, each 1 cycle after its request, with rd_valid=1.
- Ping-pong overlap: while reading bank 0, write frame data 200+i to bank 1 with wr_done. Third frame writes -> wr_ready=0, writes dropped, err_flags[0]=1. rd_release -> wr_ready=1; bank 1 reads return 200..215.
- Underflow and range: rd_req with rd_avail=0 -> rd_valid=0, err_flags[1]=1. wr_addr=16 -> dropped, err_flags[2]=1, bank state unchanged.
- Simultaneous edges: wr_done on bank 1 and rd_release on bank 0 in the same cycle -> next cycle wr_bank=0, rd_bank=1, rd_avail=1. A level-held wr_done for 5 cycles counts once.
- FMAP_BUF_CLEAR_EN: release bank 0 -> wr_ready=0 for 16 cycles when wr_bank=0. After the next frame's wr_done without writes, reads return 0.
